// File: rtl/dct_block_arbiter.sv
// dct_block_arbiter: round-robin sharing of one 8x8 DCT engine between
// N_REQ block sources. One block in flight; results are tagged with the
// source index. Optional perf counters under `DCT_ARB_PERF_EN.
module dct_block_arbiter #(
  parameter int N_REQ       = 3,
  parameter int IN_W        = 32,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req_valid,
  output logic [N_REQ-1:0]            req_ready,
  input  logic [N_REQ*64*IN_W-1:0]    req_data,
  input  logic [N_REQ-1:0]            req_mask,
  output logic                        eng_in_valid,
  input  logic                        eng_in_ready,
  output logic [64*IN_W-1:0]          eng_in_data,
  input  logic                        eng_out_valid,
  output logic                        eng_out_ready,
  input  logic [64*IN_W-1:0]          eng_out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [64*IN_W-1:0]          out_data,
  output logic [$clog2(N_REQ)-1:0]    out_id,
  output logic                        busy,
  output logic                        err_timeout
`ifdef DCT_ARB_PERF_EN
  ,
  output logic [31:0]                 perf_blocks,
  output logic [31:0]                 perf_busy_cyc
`endif
);

  localparam int DW   = 64 * IN_W;
  localparam int ID_W = $clog2(N_REQ);
  localparam int CW   = $clog2(TIMEOUT_CYC + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_BUSY  = 2'd2;

  logic [1:0]       r_state;
  logic [ID_W-1:0]  r_gnt_id;
  logic [ID_W-1:0]  r_rr_ptr;
  logic [CW-1:0]    r_cnt;
  logic             r_err;
  logic [N_REQ-1:0] w_elig;
  logic [ID_W-1:0]  w_idx;
  logic [ID_W-1:0]  w_gnt_idx;
  logic             w_found;
  logic [DW-1:0]    w_in_mux;
  logic             w_out_hs;

  assign w_elig   = req_valid & req_mask;
  assign w_out_hs = (r_state == S_BUSY) && eng_out_valid && out_ready;

  // Round-robin search: first eligible index after rr_ptr, with wrap.
  always_comb begin
    w_found   = 1'b0;
    w_gnt_idx = '0;
    w_idx     = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      w_idx = ID_W'((32'(r_rr_ptr) + k) % N_REQ);
      if (!w_found && w_elig[w_idx]) begin
        w_found   = 1'b1;
        w_gnt_idx = w_idx;
      end
    end
  end

  // Block mux from the granted requester to the engine input.
  always_comb begin
    w_in_mux = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (r_gnt_id == ID_W'(i)) w_in_mux = req_data[i*DW +: DW];
    end
  end

  // Accept pulse to the granted requester on the engine input handshake.
  always_comb begin
    req_ready = '0;
    if (r_state == S_ISSUE && eng_in_ready) req_ready[r_gnt_id] = 1'b1;
  end

  assign eng_in_valid  = (r_state == S_ISSUE);
  assign eng_in_data   = w_in_mux;
  assign out_valid     = (r_state == S_BUSY) && eng_out_valid;
  assign eng_out_ready = (r_state == S_BUSY) && out_ready;
  assign out_data      = eng_out_data;
  assign out_id        = r_gnt_id;
  assign busy          = (r_state != S_IDLE);
  assign err_timeout   = r_err;

  // Grant/issue/wait FSM with saturating busy counter and sticky timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_gnt_id <= '0;
      r_rr_ptr <= ID_W'(N_REQ - 1);
      r_cnt    <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_gnt_id <= w_gnt_idx;
            r_rr_ptr <= w_gnt_idx;
            r_state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (eng_in_ready) begin
            r_cnt   <= '0;
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (r_cnt != CW'(TIMEOUT_CYC)) r_cnt <= r_cnt + 1'b1;
          // Flag on the cycle the count reaches TIMEOUT_CYC.
          if (r_cnt >= CW'(TIMEOUT_CYC - 1)) r_err <= 1'b1;
          if (w_out_hs) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef DCT_ARB_PERF_EN
  logic [31:0] r_perf_blocks;
  logic [31:0] r_perf_busy;

  // Completed-result and busy-cycle counters, free-running with wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_blocks <= '0;
      r_perf_busy   <= '0;
    end else begin
      if (w_out_hs) r_perf_blocks <= r_perf_blocks + 32'd1;
      if (r_state != S_IDLE) r_perf_busy <= r_perf_busy + 32'd1;
    end
  end

  assign perf_blocks   = r_perf_blocks;
  assign perf_busy_cyc = r_perf_busy;
`endif

endmodule

// File: tb/tb_dct_block_arbiter.sv
// Directed bench for dct_block_arbiter (N_REQ=3, TIMEOUT_CYC=16).
module tb_dct_block_arbiter;

  localparam int N    = 3;
  localparam int IN_W = 32;
  localparam int DW   = 64 * IN_W;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*DW-1:0]   req_data;
  logic [N-1:0]      req_mask;
  logic              eng_in_valid;
  logic              eng_in_ready;
  logic [DW-1:0]     eng_in_data;
  logic              eng_out_valid;
  logic              eng_out_ready;
  logic [DW-1:0]     eng_out_data;
  logic              out_valid;
  logic              out_ready;
  logic [DW-1:0]     out_data;
  logic [1:0]        out_id;
  logic              busy;
  logic              err_timeout;
`ifdef DCT_ARB_PERF_EN
  logic [31:0]       perf_blocks;
  logic [31:0]       perf_busy_cyc;
`endif

  int errors = 0;
  int checks = 0;
  int ready_cycles = 0;
  int rr1_cycles = 0;

  dct_block_arbiter #(.N_REQ(N), .IN_W(IN_W), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .req_mask(req_mask),
    .eng_in_valid(eng_in_valid), .eng_in_ready(eng_in_ready),
    .eng_in_data(eng_in_data),
    .eng_out_valid(eng_out_valid), .eng_out_ready(eng_out_ready),
    .eng_out_data(eng_out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_id(out_id), .busy(busy), .err_timeout(err_timeout)
`ifdef DCT_ARB_PERF_EN
    , .perf_blocks(perf_blocks), .perf_busy_cyc(perf_busy_cyc)
`endif
  );

  always #5 clk = ~clk;

  // Handshake-cycle monitors.
  always @(posedge clk) begin
    if (!rst && (|req_ready)) ready_cycles <= ready_cycles + 1;
    if (!rst && req_ready[1]) rr1_cycles <= rr1_cycles + 1;
  end

  function automatic logic [DW-1:0] blk(input int i);
    logic [DW-1:0] r;
    r = '0;
    for (int j = 0; j < 64; j++)
      r[j*IN_W +: IN_W] = 32'hA000_005C | (32'(i) << 16) | (32'(j) << 8);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    req_valid = '0; req_mask = '1; eng_in_ready = 1'b0;
    eng_out_valid = 1'b0; out_ready = 1'b0; eng_out_data = '0;
    tick();
    rst = 1'b0;
  endtask

  // Runs one block end to end and reports what was observed.
  task automatic do_block(input int lat, output int gid, output int oid,
                          output bit dok, output bit tmo);
    int n;
    logic [DW-1:0] cap;
    gid = -1; oid = -1; dok = 1'b0; tmo = 1'b0;
    eng_in_ready = 1'b1; eng_out_valid = 1'b0; out_ready = 1'b1;
    #1;
    n = 0;
    while (!eng_in_valid && n < 50) begin tick(); n++; end
    if (!eng_in_valid) begin tmo = 1'b1; eng_in_ready = 1'b0; return; end
    if ($countones(req_ready) == 1)
      for (int i = 0; i < N; i++) if (req_ready[i]) gid = i;
    cap = eng_in_data;
    dok = (gid >= 0) && (cap == blk(gid));
    tick();
    eng_in_ready = 1'b0;
    repeat (lat - 1) tick();
    eng_out_valid = 1'b1; eng_out_data = ~cap;
    #1;
    if (out_valid) oid = int'(out_id);
    dok = dok && out_valid && (gid >= 0) && (out_data == ~blk(gid));
    tick();
    eng_out_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '1; req_mask = '1; eng_in_ready = 1'b1;
    eng_out_valid = 1'b1; out_ready = 1'b1; eng_out_data = '0;
    tick(); tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL rst_req_ready: got %b want 000", req_ready); end
    checks++; if (eng_in_valid !== 1'b0) begin errors++; $display("FAIL rst_eng_in_valid: got %b want 0", eng_in_valid); end
    checks++; if (eng_out_ready !== 1'b0) begin errors++; $display("FAIL rst_eng_out_ready: got %b want 0", eng_out_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", err_timeout); end
    checks++; if (out_id !== 2'd0) begin errors++; $display("FAIL rst_out_id: got %0d want 0", out_id); end
    rst = 1'b0; req_valid = '0; eng_in_ready = 1'b0; eng_out_valid = 1'b0;
  endtask

  task automatic test_single();
    apply_reset();
    req_valid = 3'b010; eng_in_ready = 1'b1;
    #1;
    checks++; if (eng_in_valid !== 1'b0) begin errors++; $display("FAIL single_idle_valid: got %b want 0", eng_in_valid); end
    tick();
    checks++; if (eng_in_valid !== 1'b1) begin errors++; $display("FAIL single_issue_valid: got %b want 1", eng_in_valid); end
    checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL single_req_ready: got %b want 010", req_ready); end
    checks++; if (eng_in_data !== blk(1)) begin errors++; $display("FAIL single_in_data: got %h want %h", eng_in_data[31:0], blk(1) >> 0); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy); end
    tick();
    req_valid = '0; eng_in_ready = 1'b0;
    #1;
    checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL single_busy_ready: got %b want 000", req_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_early_out: got %b want 0", out_valid); end
    repeat (18) tick();
    eng_out_valid = 1'b1; eng_out_data = ~blk(1); out_ready = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_out_valid: got %b want 1", out_valid); end
    checks++; if (out_id !== 2'd1) begin errors++; $display("FAIL single_out_id: got %0d want 1", out_id); end
    checks++; if (out_data !== ~blk(1)) begin errors++; $display("FAIL single_out_data: got %h want %h", out_data[31:0], ~32'hA001_005C); end
    checks++; if (eng_out_ready !== 1'b1) begin errors++; $display("FAIL single_eng_out_ready: got %b want 1", eng_out_ready); end
    tick();
    eng_out_valid = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_fall: got %b want 0", busy); end
  endtask

  task automatic test_round_robin();
    int gid, oid; bit dok, tmo;
    apply_reset();
    req_valid = 3'b111;
    for (int b = 0; b < 6; b++) begin
      do_block(3, gid, oid, dok, tmo);
      checks++; if (tmo) begin errors++; $display("FAIL rr_timeout[%0d]: got 1 want 0", b); end
      checks++; if (gid != b % 3) begin errors++; $display("FAIL rr_grant[%0d]: got %0d want %0d", b, gid, b % 3); end
      checks++; if (oid != b % 3) begin errors++; $display("FAIL rr_out_id[%0d]: got %0d want %0d", b, oid, b % 3); end
      checks++; if (!dok) begin errors++; $display("FAIL rr_data[%0d]: got 0 want 1", b); end
    end
    req_valid = '0;
`ifdef DCT_ARB_PERF_EN
    checks++; if (perf_blocks !== 32'd6) begin errors++; $display("FAIL rr_perf_blocks: got %0d want 6", perf_blocks); end
`endif
  endtask

  task automatic test_mask();
    int gid, oid, r1; bit dok, tmo;
    int exp_g[4] = '{0, 2, 0, 2};
    apply_reset();
    req_mask = 3'b101; req_valid = 3'b111;
    r1 = rr1_cycles;
    for (int b = 0; b < 4; b++) begin
      do_block(2, gid, oid, dok, tmo);
      checks++; if (gid != exp_g[b]) begin errors++; $display("FAIL mask_grant[%0d]: got %0d want %0d", b, gid, exp_g[b]); end
      checks++; if (oid != exp_g[b]) begin errors++; $display("FAIL mask_out_id[%0d]: got %0d want %0d", b, oid, exp_g[b]); end
    end
    req_valid = '0;
    checks++; if (rr1_cycles != r1) begin errors++; $display("FAIL mask_ready1: got %0d want 0", rr1_cycles - r1); end
  endtask

  task automatic test_back_to_back();
    int p0;
    apply_reset();
    req_valid = 3'b001; eng_in_ready = 1'b0; out_ready = 1'b0;
    p0 = ready_cycles;
    tick();
    for (int c = 0; c < 5; c++) begin
      checks++; if (eng_in_valid !== 1'b1) begin errors++; $display("FAIL bp_in_valid[%0d]: got %b want 1", c, eng_in_valid); end
      checks++; if (eng_in_data !== blk(0)) begin errors++; $display("FAIL bp_in_data[%0d]: got %h want a000005c", c, eng_in_data[31:0]); end
      checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL bp_ready_early[%0d]: got %b want 000", c, req_ready); end
      tick();
    end
    eng_in_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL bp_ready: got %b want 001", req_ready); end
    tick();
    eng_in_ready = 1'b0; req_valid = 3'b110;
    eng_out_valid = 1'b1; eng_out_data = ~blk(0);
    #1;
    for (int c = 0; c < 7; c++) begin
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid[%0d]: got %b want 1", c, out_valid); end
      checks++; if (eng_out_ready !== 1'b0) begin errors++; $display("FAIL bp_eng_out_ready[%0d]: got %b want 0", c, eng_out_ready); end
      checks++; if (eng_in_valid !== 1'b0) begin errors++; $display("FAIL bp_no_grant[%0d]: got %b want 0", c, eng_in_valid); end
      tick();
    end
    out_ready = 1'b1;
    #1;
    checks++; if (eng_out_ready !== 1'b1) begin errors++; $display("FAIL bp_eng_out_ready_hi: got %b want 1", eng_out_ready); end
    checks++; if (out_id !== 2'd0) begin errors++; $display("FAIL bp_out_id: got %0d want 0", out_id); end
    tick();
    req_valid = '0; eng_out_valid = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_busy_fall: got %b want 0", busy); end
    tick();
    checks++; if (eng_in_valid !== 1'b0) begin errors++; $display("FAIL bp_extra_grant: got %b want 0", eng_in_valid); end
    checks++; if (ready_cycles - p0 != 1) begin errors++; $display("FAIL bp_pulses: got %0d want 1", ready_cycles - p0); end
  endtask

  task automatic test_timeout();
    apply_reset();
    req_valid = 3'b001; eng_in_ready = 1'b1; out_ready = 1'b1;
    tick();
    tick();
    req_valid = '0; eng_in_ready = 1'b0;
    repeat (15) tick();
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL to_early: got %b want 0", err_timeout); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL to_busy: got %b want 1", busy); end
    tick();
    checks++; if (err_timeout !== 1'b1) begin errors++; $display("FAIL to_set: got %b want 1", err_timeout); end
    repeat (5) tick();
    eng_out_valid = 1'b1; eng_out_data = ~blk(0);
    #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL to_late_valid: got %b want 1", out_valid); end
    tick();
    eng_out_valid = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL to_idle: got %b want 0", busy); end
    checks++; if (err_timeout !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b want 1", err_timeout); end
    rst = 1'b1;
    tick();
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL to_clear: got %b want 0", err_timeout); end
    rst = 1'b0;
  endtask

  task automatic test_reset_mid();
    int gid, oid; bit dok, tmo;
    apply_reset();
    req_valid = 3'b111;
    do_block(2, gid, oid, dok, tmo);
    checks++; if (gid != 0) begin errors++; $display("FAIL rm_first: got %0d want 0", gid); end
    eng_in_ready = 1'b1;
    tick();
    checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL rm_second: got %b want 010", req_ready); end
    tick();
    eng_in_ready = 1'b0; eng_out_valid = 1'b1; out_ready = 1'b0;
    #1;
    rst = 1'b1; out_ready = 1'b1;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_busy: got %b want 0", busy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rm_out_valid: got %b want 0", out_valid); end
    checks++; if (eng_out_ready !== 1'b0) begin errors++; $display("FAIL rm_eng_out_ready: got %b want 0", eng_out_ready); end
    checks++; if (eng_in_valid !== 1'b0) begin errors++; $display("FAIL rm_eng_in_valid: got %b want 0", eng_in_valid); end
    checks++; if (out_id !== 2'd0) begin errors++; $display("FAIL rm_out_id: got %0d want 0", out_id); end
`ifdef DCT_ARB_PERF_EN
    checks++; if (perf_blocks !== 32'd0) begin errors++; $display("FAIL rm_perf_blocks: got %0d want 0", perf_blocks); end
    checks++; if (perf_busy_cyc !== 32'd0) begin errors++; $display("FAIL rm_perf_busy: got %0d want 0", perf_busy_cyc); end
`endif
    rst = 1'b0; eng_out_valid = 1'b0; eng_in_ready = 1'b1; req_valid = 3'b111;
    tick();
    checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL rm_regrant: got %b want 001", req_ready); end
    req_valid = '0; eng_in_ready = 1'b0;
  endtask

  initial begin
    req_data = {blk(2), blk(1), blk(0)};
    test_reset();
    test_single();
    test_round_robin();
    test_mask();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
